// File: rtl/issue_scoreboard_pkg.sv
// Shared constants and types for the in-order issue scoreboard.
// Holds the architectural sizes, default multiplier occupancy and opcode values.
// Decoder-side opcode constants live here so every stage agrees on encodings.
package issue_scoreboard_pkg;

   localparam int WORD_SIZE           = 32;
   localparam int ARCH_REG_INDEX_SIZE = 5;
   localparam int NUM_REGS            = 32;
   localparam int MUL_LATENCY         = 4;

   localparam logic [6:0] OPCODE_OP     = 7'b0110011;
   localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
   localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
   localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
   localparam logic [6:0] OPCODE_JAL    = 7'b1101111;

   // Reasons an instruction may be held in decode.
   typedef struct packed {
      logic raw;
      logic waw;
      logic mul;
   } hazard_t;

   // Counter width able to hold the value lat (lat itself is loaded).
   function automatic int occ_cnt_width(input int lat);
      return $clog2(lat + 1);
   endfunction

endpackage

// File: rtl/issue_scoreboard_mul_occupancy_counter.sv
// Occupancy tracker for a non-pipelined multi-cycle unit.
// Latency: busy rises the cycle after load and stays high for LATENCY cycles.
// Backpressure: none internally; the caller must not load while busy.
// Ports: clk, rst_n (async active-low), flush (clears), load (start op), busy.
module mul_occupancy_counter
   import issue_scoreboard_pkg::*;
#(
   parameter int LATENCY = 4,
   parameter int CNT_W   = occ_cnt_width(LATENCY)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic flush,
   input  logic load,
   output logic busy
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (flush) begin
         cnt_d = '0;
      end else if (load) begin
         cnt_d = CNT_W'(LATENCY);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign busy = (cnt_q != '0);

endmodule

// File: rtl/issue_scoreboard.sv
// In-order issue controller: holds decode on RAW/WAW hazards or a busy multiplier.
// Latency: issue/stall are combinational; register busy bits update at the next edge.
// Backpressure: stalls when ex_ready is low; decode must hold its instruction while stall.
// Ports: dec_* (decoded instruction + use flags), ex_ready, wb_valid/wb_rd (release),
//        flush, issue/stall (handshake to execute/decode), mul_busy, pending (debug bitmap).
module issue_scoreboard
   import issue_scoreboard_pkg::*;
#(
   parameter int NUM_REGS    = issue_scoreboard_pkg::NUM_REGS,
   parameter int REG_IDX_W   = ARCH_REG_INDEX_SIZE,
   parameter int MUL_LATENCY = issue_scoreboard_pkg::MUL_LATENCY
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 dec_valid,
   input  logic [REG_IDX_W-1:0] dec_rs1,
   input  logic [REG_IDX_W-1:0] dec_rs2,
   input  logic [REG_IDX_W-1:0] dec_rd,
   input  logic                 dec_uses_rs1,
   input  logic                 dec_uses_rs2,
   input  logic                 dec_writes_rd,
   input  logic                 dec_is_mul,
   input  logic                 ex_ready,
   input  logic                 wb_valid,
   input  logic [REG_IDX_W-1:0] wb_rd,
   input  logic                 flush,
   output logic                 issue,
   output logic                 stall,
   output logic                 mul_busy,
   output logic [NUM_REGS-1:0]  pending
);

   logic [NUM_REGS-1:0] pending_q;
   logic [NUM_REGS-1:0] pending_d;
   logic [NUM_REGS-1:0] clr_wb;
   logic [NUM_REGS-1:0] eff;
   hazard_t             haz;
   logic                set_rd;

   always_comb begin
      clr_wb = '0;
      if (wb_valid) begin
         clr_wb[wb_rd] = 1'b1;
      end
      // A writeback landing this cycle is already visible through the
      // register-file write-through, so it no longer blocks a consumer.
      eff = pending_q & ~clr_wb;

      haz.raw = (dec_uses_rs1 & eff[dec_rs1]) | (dec_uses_rs2 & eff[dec_rs2]);
      haz.waw = dec_writes_rd & (dec_rd != '0) & eff[dec_rd];
      haz.mul = dec_is_mul & mul_busy;

      issue  = dec_valid & ex_ready & ~flush & ~(|haz);
      stall  = dec_valid & ~issue;
      set_rd = issue & dec_writes_rd & (dec_rd != '0);

      if (flush) begin
         pending_d = '0;
      end else begin
         // Clear first, then set: a new producer of rd outranks the
         // retiring older write to the same register.
         pending_d = pending_q & ~clr_wb;
         if (set_rd) begin
            pending_d[dec_rd] = 1'b1;
         end
      end
      pending_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q <= '0;
      end else begin
         pending_q <= pending_d;
      end
   end

   assign pending = pending_q;

   mul_occupancy_counter #(
      .LATENCY (MUL_LATENCY)
   ) u_mul_occ (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .load  (issue & dec_is_mul),
      .busy  (mul_busy)
   );

endmodule

// File: doc/issue_scoreboard.md
# issue_scoreboard

In-order issue controller between the decode stage and the execute stage. It tracks which architectural registers have a write still in flight. It stalls a decoded instruction on a RAW hazard, a WAW hazard, or a busy multi-cycle multiplier, and it releases registers as writebacks arrive. Decode supplies register indices and use flags; this block alone decides when an instruction issues.

## Interface
Parameters:
- NUM_REGS, 32, number of architectural registers; register 0 is hardwired zero.
- REG_IDX_W, `ARCH_REG_INDEX_SIZE, width of a register index.
- MUL_LATENCY, 4, cycles the non-pipelined multiplier is occupied per MUL; legal range 1..15.

Ports (reset is asynchronous, active-low):
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- dec_valid  in  1  decode holds a valid instruction.
- dec_rs1  in  REG_IDX_W  source register 1 index.
- dec_rs2  in  REG_IDX_W  source register 2 index.
- dec_rd  in  REG_IDX_W  destination register index.
- dec_uses_rs1  in  1  instruction reads rs1 (R, I, S, B types).
- dec_uses_rs2  in  1  instruction reads rs2 (R, S, B types).
- dec_writes_rd  in  1  instruction writes rd (R, I, J types).
- dec_is_mul  in  1  instruction uses the multiplier.
- ex_ready  in  1  execute stage accepts an instruction this cycle.
- wb_valid  in  1  a writeback completes this cycle.
- wb_rd  in  REG_IDX_W  register written back.
- flush  in  1  kill all in-flight work (mispredict or exception).
- issue  out  1  the instruction moves to execute this cycle.
- stall  out  1  dec_valid is high and issue is low.
- mul_busy  out  1  multiplier occupied.
- pending  out  NUM_REGS  per-register in-flight bitmap (debug/verification).

## Operation
- State:
  - pending[NUM_REGS-1:0]; bit 0 is constant 0.
  - mul_cnt, width clog2(MUL_LATENCY+1).
- clr_wb[r] = wb_valid & (wb_rd == r).
- Effective pending: eff[r] = pending[r] & ~clr_wb[r]. A same-cycle writeback counts as already available; the register file write-through supplies the value.
- Hazard terms:
  - raw = (dec_uses_rs1 & eff[dec_rs1]) | (dec_uses_rs2 & eff[dec_rs2]).
  - waw = dec_writes_rd & (dec_rd != 0) & eff[dec_rd].
  - struct = dec_is_mul & mul_busy.
- Issue and stall:
  - issue = dec_valid & ex_ready & ~flush & ~raw & ~waw & ~struct.
  - stall = dec_valid & ~issue.
- Next pending, priority high to low:
  - flush: all bits 0.
  - issue & dec_writes_rd & dec_rd != 0: set bit dec_rd. A set wins over a same-cycle clr_wb on the same register.
  - otherwise: clear every bit where clr_wb is high.
- A writeback to a register that is not pending, or to register 0, is ignored.
- mul_cnt, priority high to low:
  - flush: 0.
  - issue & dec_is_mul: load MUL_LATENCY.
  - mul_cnt != 0: decrement.
- mul_busy = (mul_cnt != 0).
- Reset values: pending = 0, mul_cnt = 0, so mul_busy = 0. issue and stall are combinational and follow dec_valid and ex_ready immediately after reset.

## Timing
- issue and stall are combinational from the current inputs and state; there is no added latency.
- A register set by an issue at edge t reads as pending from cycle t+1.
- A dependent instruction may issue in the same cycle the producer's wb_valid is high.
- MUL issued in cycle t: mul_busy is high in cycles t+1 .. t+MUL_LATENCY. The next MUL may issue in cycle t+MUL_LATENCY+1.
- Flush in cycle t: issue is 0 in cycle t. All pending bits and mul_busy are 0 from cycle t+1.
- Reset assertion mid-operation clears all state immediately and asynchronously. Deassertion is synchronized externally.
- The upstream decode register must hold its instruction while stall is high; this block does not latch decode inputs.

## Structure
- NUM_REGS, MUL_LATENCY and the OPCODE_* constants live in the shared defines file, alongside WORD_SIZE and ARCH_REG_INDEX_SIZE.
- The use flags (uses_rs1, uses_rs2, writes_rd, is_mul) are derived from the opcode in the decoder and passed in. This block does not decode opcodes.
- One natural sub-module, mul_occupancy_counter: the load, decrement and busy logic, reusable for other multi-cycle units.

## Test plan
- Back-to-back RAW: issue ADD rd=5; next cycle ADD rs1=5 with no writeback -> stall=1, issue=0. Then wb_valid=1, wb_rd=5 -> issue=1 in that same cycle, and pending[5] is 0 afterwards.
- WAW and x0: LOAD rd=7 pending, then ALU rd=7 -> stall. Any instruction with rd=0 -> pending stays 0 and no stall is caused on rs1=0.
- Multiplier occupancy with MUL_LATENCY=4: MUL issued in cycle 10 -> mul_busy=1 in cycles 11..14. An independent MUL stalls in cycles 11..14 and issues in cycle 15. A non-MUL independent instruction issues in cycle 11.
- Simultaneous set and clear: in one cycle, wb_rd=9 and an issue with rd=9 -> pending[9]=1 next cycle.
- Flush: pending={3,5,12}, mul_cnt=2, flush=1 with dec_valid=1 -> issue=0 that cycle; next cycle pending=0 and mul_busy=0.
- Backpressure and reset: ex_ready=0 with no hazards -> stall=1 and pending unchanged. Assert rst_n=0 mid-MUL with pending set -> pending=0 and mul_busy=0 immediately, without waiting for a clock edge.
